op_decode: RTL and testbench
============================

OP_DECODE -- requirements
Module: op_decode

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have port in_valid, input, 1, upstream instruction valid.
REQ-004 SHALL have port in_ready, output, 1, decoder can accept an instruction this cycle.
REQ-005 SHALL have port instr, input, 32, RV32I instruction word.
REQ-006 SHALL have port out_valid, output, 1, decoded entry present.
REQ-007 SHALL have port out_ready, input, 1, downstream consumes the entry this cycle.
REQ-008 SHALL have port op, output, 6, ALU op code: 1 add, 2 sub, 3 xor, 4 or, 5 and, 6 sll, 7 sra, 8 srl, 9 slt, 10 sltu, 0 none.
REQ-009 SHALL have ports rs1, rs2 and rd, each output, 5, register indices instr[19:15], instr[24:20] and instr[11:7].
REQ-010 SHALL have port imm, output, 32, immediate operand.
REQ-011 SHALL have port use_imm, output, 1, ALU second operand is imm rather than register rs2.
REQ-012 SHALL have port illegal, output, 1, instruction is not a supported ALU instruction.
REQ-013 SHALL have port dec_count, output, 16, count of entries consumed downstream.

Function
REQ-014 SHALL decode opcode 0110011 (R-type) by funct3/funct7 with funct7=0000000:
- funct3 000 add(1), 001 sll(6), 010 slt(9), 011 sltu(10)
- funct3 100 xor(3), 101 srl(8), 110 or(4), 111 and(5)
REQ-015 SHALL decode R-type funct7=0100000 as: funct3 000 sub(2), 101 sra(7); other R-type funct7/funct3 combinations are illegal.
REQ-016 SHALL decode R-type with use_imm=0 and imm=0.
REQ-017 SHALL decode opcode 0010011 (I-type) with use_imm=1:
- funct3 000 add, 010 slt, 011 sltu, 100 xor, 110 or, 111 and
- for these, imm = sign-extended instr[31:20]
REQ-018 SHALL decode I-type shifts as follows, other shift funct7 values being illegal:
- funct3 001 with instr[31:25]=0 -> sll
- funct3 101 with instr[31:25]=0 -> srl
- funct3 101 with instr[31:25]=0100000 -> sra
- shift imm = zero-extended instr[24:20]
REQ-019 SHALL, for any other opcode or illegal encoding, output op=0, illegal=1, use_imm=0, imm=0, and still deliver the entry (no drop).
REQ-020 SHALL register decode results: an instruction accepted on edge N appears on outputs after edge N (latency 1) when the output stage is empty or draining.
REQ-021 SHALL transfer on the input side only when in_valid && in_ready, and on the output side only when out_valid && out_ready.
REQ-022 SHALL contain a two-entry buffer (output register plus skid register) with states EMPTY, ONE, FULL:
- EMPTY -> ONE on input transfer.
- ONE -> FULL on input transfer without output transfer.
- ONE -> EMPTY on output transfer without input transfer.
- FULL -> ONE on output transfer.
- Simultaneous input and output transfer in ONE stays in ONE.
REQ-023 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in FULL, derived from registered state only (no combinational path from out_ready).
REQ-024 SHALL hold op/rs1/rs2/rd/imm/use_imm/illegal stable while out_valid=1 and out_ready=0.
REQ-025 SHALL preserve strict FIFO order; on an output transfer from FULL, the skid entry moves to the output register on the same edge.
REQ-026 SHALL increment dec_count by 1 per output transfer and wrap from 0xFFFF to 0x0000.

Reset
REQ-027 SHALL, while rst_n=0 at a rising edge:
- go to EMPTY with out_valid=0 and in_ready=0 during reset
- clear op, rs1, rs2, rd, imm, use_imm, illegal and dec_count to 0
REQ-028 SHALL drive in_ready=1 on the first cycle after rst_n returns high.
REQ-029 SHALL discard any buffered entries on reset mid-operation; no entry from before reset appears afterwards.

Verification
REQ-030 SHALL pass these directed scenarios:
- instr 0x002081B3 accepted -> next cycle out_valid=1, op=1, rs1=1, rs2=2, rd=3, use_imm=0, illegal=0.
- instr 0x407302B3 -> op=2, rs1=6, rs2=7, rd=5.
- 0xFFF00093 -> op=1, use_imm=1, imm=0xFFFFFFFF, rd=1.
- 0x40315113 -> op=7, imm=0x00000003, rs1=2, rd=2.
- 0x00000000 -> op=0, illegal=1, entry delivered.
- Backpressure: out_ready=0, three back-to-back in_valid instructions A, B, C -> A and B accepted, in_ready=0 with C held. Then raise out_ready -> A, B, C delivered in order, dec_count=3.
- Reset mid-operation: rst_n=0 while FULL -> out_valid=0 and dec_count=0 next cycle; in_ready=1 after release.

Source files
------------

// File: rtl/op_decode_if.sv
// ============================================================================
// Module      : op_decode_if
// Description : Valid/ready handshake and decoded-entry bundle for op_decode.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface op_decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
    logic [15:0] dec_count;

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, op, rs1, rs2, rd, imm, use_imm, illegal, dec_count
    );

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, op, rs1, rs2, rd, imm, use_imm, illegal, dec_count
    );
endinterface

`default_nettype wire

// File: rtl/op_decode.sv
// ============================================================================
// Module      : op_decode
// Description : RV32I ALU-instruction decoder with a two-entry skid buffer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module op_decode (
    input  logic          clk,
    input  logic          rst_n,
    op_decode_if.slave    bus
);

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    localparam logic [6:0] c_opc_r   = 7'b0110011;
    localparam logic [6:0] c_opc_i   = 7'b0010011;
    localparam logic [6:0] c_f7_zero = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;

    localparam int c_pw = 55;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic            r_in_ready;
    logic [c_pw-1:0] r_out;
    logic [c_pw-1:0] r_skid;
    logic [15:0]     r_count;

    logic            w_out_valid;
    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_load_out;
    logic            w_load_skid;
    logic            w_from_skid;

    logic [5:0]      w_op;
    logic [31:0]     w_imm;
    logic            w_use_imm;
    logic            w_illegal;
    logic [c_pw-1:0] w_dec;

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;

    assign w_opc = bus.instr[6:0];
    assign w_f3  = bus.instr[14:12];
    assign w_f7  = bus.instr[31:25];

    // Instruction decode; any unsupported encoding falls through to op=0.
    always_comb begin
        w_op      = 6'd0;
        w_imm     = 32'd0;
        w_use_imm = 1'b0;
        if (w_opc == c_opc_r) begin
            if (w_f7 == c_f7_zero) begin
                case (w_f3)
                    3'b000:  w_op = 6'd1;
                    3'b001:  w_op = 6'd6;
                    3'b010:  w_op = 6'd9;
                    3'b011:  w_op = 6'd10;
                    3'b100:  w_op = 6'd3;
                    3'b101:  w_op = 6'd8;
                    3'b110:  w_op = 6'd4;
                    default: w_op = 6'd5;
                endcase
            end else if (w_f7 == c_f7_alt) begin
                if (w_f3 == 3'b000)      w_op = 6'd2;
                else if (w_f3 == 3'b101) w_op = 6'd7;
            end
        end else if (w_opc == c_opc_i) begin
            case (w_f3)
                3'b000:  w_op = 6'd1;
                3'b010:  w_op = 6'd9;
                3'b011:  w_op = 6'd10;
                3'b100:  w_op = 6'd3;
                3'b110:  w_op = 6'd4;
                3'b111:  w_op = 6'd5;
                3'b001:  w_op = (w_f7 == c_f7_zero) ? 6'd6 : 6'd0;
                default: begin
                    if (w_f7 == c_f7_zero)     w_op = 6'd8;
                    else if (w_f7 == c_f7_alt) w_op = 6'd7;
                end
            endcase
            if (w_op != 6'd0) begin
                w_use_imm = 1'b1;
                if (w_f3 == 3'b001 || w_f3 == 3'b101)
                    w_imm = {27'd0, bus.instr[24:20]};
                else
                    w_imm = {{20{bus.instr[31]}}, bus.instr[31:20]};
            end
        end
    end

    assign w_illegal = (w_op == 6'd0);
    assign w_dec     = {w_op, bus.instr[19:15], bus.instr[24:20], bus.instr[11:7],
                        w_imm, w_use_imm, w_illegal};

    assign w_in_xfer  = bus.in_valid & r_in_ready;
    assign w_out_xfer = w_out_valid & bus.out_ready;

    // in_ready is registered from the next state so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_empty;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != c_st_full);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_empty: if (w_in_xfer) w_next = c_st_one;
            c_st_one: begin
                if (w_in_xfer && !w_out_xfer)      w_next = c_st_full;
                else if (!w_in_xfer && w_out_xfer) w_next = c_st_empty;
            end
            c_st_full:  if (w_out_xfer) w_next = c_st_one;
            default:    w_next = c_st_empty;
        endcase
    end

    always_comb begin
        w_out_valid = (r_state != c_st_empty);
        w_load_out  = 1'b0;
        w_load_skid = 1'b0;
        w_from_skid = 1'b0;
        case (r_state)
            c_st_empty: w_load_out = w_in_xfer;
            c_st_one: begin
                if (w_in_xfer && w_out_xfer) w_load_out  = 1'b1;
                else if (w_in_xfer)          w_load_skid = 1'b1;
            end
            c_st_full: begin
                w_load_out  = w_out_xfer;
                w_from_skid = w_out_xfer;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_skid  <= '0;
            r_count <= 16'd0;
        end else begin
            if (w_load_out)  r_out  <= w_from_skid ? r_skid : w_dec;
            if (w_load_skid) r_skid <= w_dec;
            if (w_out_xfer)  r_count <= r_count + 16'd1;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.op        = r_out[54:49];
    assign bus.rs1       = r_out[48:44];
    assign bus.rs2       = r_out[43:39];
    assign bus.rd        = r_out[38:34];
    assign bus.imm       = r_out[33:2];
    assign bus.use_imm   = r_out[1];
    assign bus.illegal   = r_out[0];
    assign bus.dec_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_op_decode.sv
// ============================================================================
// Module      : tb_op_decode
// Description : Randomized and directed checks of op_decode against a queue model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_op_decode;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    op_decode_if bus ();

    op_decode u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] q[$];
    logic [15:0] exp_count;
    logic        last_rst_n;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode from the instruction-set tables.
    function automatic void ref_dec(input logic [31:0] w, output int op,
                                    output logic [31:0] imm, output logic ui, output logic ill);
        int rops[8] = '{1, 6, 9, 10, 3, 8, 4, 5};
        int f3  = int'(w[14:12]);
        int f7  = int'(w[31:25]);
        int opc = int'(w[6:0]);
        int s12 = int'(w[31:20]);
        op  = 0;
        imm = 0;
        ui  = 0;
        if (opc == 51) begin
            if (f7 == 0)                op = rops[f3];
            else if (f7 == 32 && f3 == 0) op = 2;
            else if (f7 == 32 && f3 == 5) op = 7;
        end else if (opc == 19) begin
            if (f3 == 1)      op = (f7 == 0) ? 6 : 0;
            else if (f3 == 5) op = (f7 == 0) ? 8 : ((f7 == 32) ? 7 : 0);
            else              op = rops[f3];
            if (op != 0) begin
                ui = 1;
                if (f3 == 1 || f3 == 5) imm = 32'(int'(w[24:20]));
                else                    imm = 32'((s12 >= 2048) ? s12 - 4096 : s12);
            end
        end
        ill = (op == 0);
    endfunction

    task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy);
        logic exp_ir, exp_ov, in_x, out_x;
        int          e_op;
        logic [31:0] e_imm;
        logic        e_ui, e_ill;
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.out_ready = ordy;
        @(negedge clk);
        exp_ir = last_rst_n && (q.size() < 2);
        exp_ov = (q.size() != 0);
        check("in_ready",  64'(bus.in_ready),  64'(exp_ir));
        check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
        check("dec_count", 64'(bus.dec_count), 64'(exp_count));
        if (exp_ov) begin
            ref_dec(q[0], e_op, e_imm, e_ui, e_ill);
            check("op",      64'(bus.op),      64'(e_op));
            check("rs1",     64'(bus.rs1),     64'(q[0][19:15]));
            check("rs2",     64'(bus.rs2),     64'(q[0][24:20]));
            check("rd",      64'(bus.rd),      64'(q[0][11:7]));
            check("imm",     64'(bus.imm),     64'(e_imm));
            check("use_imm", 64'(bus.use_imm), 64'(e_ui));
            check("illegal", 64'(bus.illegal), 64'(e_ill));
        end else if (!last_rst_n) begin
            check("rst_payload", {bus.op, bus.rs1, bus.rs2, bus.rd, bus.imm, bus.use_imm, bus.illegal}, 64'd0);
        end
        in_x  = v && exp_ir;
        out_x = exp_ov && ordy;
        @(posedge clk);
        last_rst_n = rst_n;
        if (!rst_n) begin
            q.delete();
            exp_count = 16'd0;
        end else begin
            if (out_x) begin
                void'(q.pop_front());
                exp_count++;
            end
            if (in_x) q.push_back(ins);
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        int sel = $urandom_range(0, 9);
        if (sel < 4)      r[6:0] = 7'b0110011;
        else if (sel < 8) r[6:0] = 7'b0010011;
        sel = $urandom_range(0, 3);
        if (sel == 0)      r[31:25] = 7'h00;
        else if (sel == 1) r[31:25] = 7'h20;
        return r;
    endfunction

    typedef struct {
        logic [31:0] ins;
        int          op;
        logic [31:0] imm;
        logic        ui;
        logic        ill;
        int          rd;
    } dir_t;

    dir_t dirs[5] = '{
        '{32'h002081B3, 1, 32'h0000_0000, 1'b0, 1'b0, 3},
        '{32'h407302B3, 2, 32'h0000_0000, 1'b0, 1'b0, 5},
        '{32'hFFF00093, 1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1},
        '{32'h40315113, 7, 32'h0000_0003, 1'b1, 1'b0, 2},
        '{32'h00000000, 0, 32'h0000_0000, 1'b0, 1'b1, 0}
    };

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        exp_count     = 16'd0;
        bus.in_valid  = 1'b0;
        bus.instr     = 32'd0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        @(posedge clk);
        last_rst_n = 1'b0;
        #1;
        cycle(1'b1, 32'h002081B3, 1'b1);
        rst_n = 1'b1;
        cycle(1'b0, 32'd0, 1'b0);
        check("ready_after_rst", 64'(bus.in_ready), 64'd1);

        // Directed decodes, one in flight at a time.
        foreach (dirs[i]) begin
            cycle(1'b1, dirs[i].ins, 1'b1);
            check("dir_valid",   64'(bus.out_valid), 64'd1);
            check("dir_op",      64'(bus.op),        64'(dirs[i].op));
            check("dir_imm",     64'(bus.imm),       64'(dirs[i].imm));
            check("dir_use_imm", 64'(bus.use_imm),   64'(dirs[i].ui));
            check("dir_illegal", 64'(bus.illegal),   64'(dirs[i].ill));
            check("dir_rd",      64'(bus.rd),        64'(dirs[i].rd));
        end
        cycle(1'b0, 32'd0, 1'b1);

        // Backpressure: A, B fill the buffer, C must wait.
        rst_n = 1'b0;
        cycle(1'b0, 32'd0, 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b1, 32'h002081B3, 1'b0);
        cycle(1'b1, 32'h407302B3, 1'b0);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        cycle(1'b1, 32'hFFF00093, 1'b0);
        check("bp_hold_op", 64'(bus.op), 64'd1);
        cycle(1'b1, 32'hFFF00093, 1'b1);
        check("bp_second_op", 64'(bus.op), 64'd2);
        cycle(1'b1, 32'hFFF00093, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        check("bp_count", 64'(bus.dec_count), 64'd3);

        // Reset while FULL.
        cycle(1'b1, 32'h40315113, 1'b0);
        cycle(1'b1, 32'h00000000, 1'b0);
        rst_n = 1'b0;
        cycle(1'b0, 32'd0, 1'b0);
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_count", 64'(bus.dec_count), 64'd0);
        rst_n = 1'b1;
        cycle(1'b0, 32'd0, 1'b1);
        check("mid_rst_ready", 64'(bus.in_ready), 64'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            cycle(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 2) != 0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
